// File: rtl/spi_cfg_master_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_cfg_master_if
// Description : Request/response handshake and SPI pin bundle for the
//               configuration-port master. The master modport faces the
//               SPI master; the slave modport faces whoever issues frames
//               and models the serial slave.
// Revision    : 1.0  initial release
// ============================================================================
interface spi_cfg_master_if #(
    parameter int FRAME_W = 16
);
    logic               start;
    logic [FRAME_W-1:0] tx_data;
    logic               busy;
    logic               done;
    logic [FRAME_W-1:0] rx_data;
    logic               ss;
    logic               sck;
    logic               mosi;
    logic               miso;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, ss, sck, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, ss, sck, mosi
    );
endinterface
`default_nettype wire

// File: rtl/spi_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_cfg_master
// Description : SPI mode-0 master for the digital_block analog-mux config
//               port. Shifts one FRAME_W-bit frame out MSB first per accepted
//               start, captures the returned miso frame and reports it with
//               a one-cycle done pulse. sck half-period is CLK_DIV clk cycles.
// Revision    : 1.0  initial release
// ============================================================================
module spi_cfg_master #(
    parameter int FRAME_W  = 16,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_cfg_master_if.master bus
);

    localparam int c_DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int c_CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int c_CS_W   = $clog2(c_CS_MAX) + 1;
    localparam int c_BIT_W  = $clog2(FRAME_W);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_CS_W-1:0]  c_SETUP_LAST = c_CS_W'(CS_SETUP - 1);
    localparam logic [c_CS_W-1:0]  c_HOLD_LAST  = c_CS_W'(CS_HOLD - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(FRAME_W - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_LOW   = 3'd2;
    localparam logic [2:0] c_ST_HIGH  = 3'd3;
    localparam logic [2:0] c_ST_HOLD  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_CS_W-1:0]  r_cs_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [FRAME_W-1:0] r_tx_sh;
    logic [FRAME_W-1:0] r_rx_sh;
    logic [FRAME_W-1:0] r_rx_data;
    logic               r_done;
    logic               w_state_change;

    assign w_state_change = (w_state_nxt != r_state);

    // State register; reset returns to IDLE from anywhere, aborting a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: each phase lasts a fixed count, HIGH loops back to LOW
    // until the last bit has been clocked.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.start)                  w_state_nxt = c_ST_SETUP;
            c_ST_SETUP: if (r_cs_cnt == c_SETUP_LAST)   w_state_nxt = c_ST_LOW;
            c_ST_LOW:   if (r_div_cnt == c_DIV_LAST)    w_state_nxt = c_ST_HIGH;
            c_ST_HIGH: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_state_nxt = (r_bit_cnt == c_BIT_LAST) ? c_ST_HOLD : c_ST_LOW;
                end
            end
            c_ST_HOLD:  if (r_cs_cnt == c_HOLD_LAST)    w_state_nxt = c_ST_IDLE;
            default:                                    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Phase counters restart on every state change so each phase length is
    // measured from its own entry cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_cs_cnt  <= '0;
        end else if (w_state_change) begin
            r_div_cnt <= '0;
            r_cs_cnt  <= '0;
        end else begin
            if (r_state == c_ST_LOW || r_state == c_ST_HIGH) begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end
            if (r_state == c_ST_SETUP || r_state == c_ST_HOLD) begin
                r_cs_cnt <= r_cs_cnt + c_CS_W'(1);
            end
        end
    end

    // Shift datapath: latch on accept, sample miso on the sck rising edge,
    // advance mosi on the sck falling edge, publish the frame on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == c_ST_IDLE && bus.start) begin
                r_tx_sh   <= bus.tx_data;
                r_bit_cnt <= '0;
            end
            if (r_state == c_ST_LOW && w_state_nxt == c_ST_HIGH) begin
                r_rx_sh <= {r_rx_sh[FRAME_W-2:0], bus.miso};
            end
            if (r_state == c_ST_HIGH && w_state_nxt == c_ST_LOW) begin
                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                r_tx_sh   <= {r_tx_sh[FRAME_W-2:0], 1'b0};
            end
            if (r_state == c_ST_HOLD && w_state_nxt == c_ST_IDLE) begin
                r_done    <= 1'b1;
                r_rx_data <= r_rx_sh;
            end
        end
    end

    // Pin outputs are straight decodes of registered state, so no glitches
    // beyond the register outputs themselves.
    assign bus.ss      = (r_state == c_ST_IDLE);
    assign bus.sck     = (r_state == c_ST_HIGH);
    assign bus.mosi    = r_tx_sh[FRAME_W-1];
    assign bus.busy    = (r_state != c_ST_IDLE);
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;

endmodule
`default_nettype wire

// File: doc/spi_cfg_master.md
Name: spi_cfg_master

Overview:
SPI mode-0 master that drives the ss/sck/mosi/miso configuration port of digital_block, the analog-mux control SPI slave. It sits in the test harness or an on-chip bring-up controller and shifts out one FRAME_W-bit configuration frame per request. It captures the frame returned on miso and reports it with a one-cycle done pulse. A programmable divider sets the sck rate from clk.

Parameters:
FRAME_W, 16, bits per frame; MSB first; >= 2
CLK_DIV, 4, clk cycles per sck half-period; >= 1
CS_SETUP, 2, clk cycles ss low before first sck rise; >= 1
CS_HOLD, 2, clk cycles ss held low after last sck fall; >= 1

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request a frame; honoured only when busy=0
tx_data  in  FRAME_W  frame to send; latched on the accepted start cycle
busy  out  1  high from the cycle after accepted start through the HOLD state
done  out  1  one-cycle pulse when the frame completes
rx_data  out  FRAME_W  last captured miso frame; updated only together with done
ss  out  1  slave select, active-low, idle high
sck  out  1  serial clock, idle low (CPOL=0)
mosi  out  1  serial data to slave
miso  in  1  serial data from slave; treated as synchronous to clk

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, ss=1, sck=0, mosi=0, busy=0, done=0, rx_data=0, shift regs and counters 0. Reset mid-frame aborts immediately: ss rises next edge, no done pulse, rx_data forced to 0.
- Mode 0: slave samples mosi on sck rise. mosi changes only while sck=0. Master samples miso on the clk edge where sck goes 0->1.
- FSM states: IDLE, SETUP, LOW, HIGH, HOLD.
- IDLE: ss=1, sck=0, busy=0. If start=1, latch tx_data into tx_sh, clear bit_cnt, go to SETUP. start while busy=1 is ignored, with no queueing.
- SETUP: ss=0, sck=0, mosi=tx_sh[FRAME_W-1]. Stays CS_SETUP cycles, then goes to LOW.
- LOW: sck=0 for CLK_DIV cycles, then goes to HIGH.
- HIGH: on entry, sck=1 and rx_sh shifts left with miso into the LSB. sck stays 1 for CLK_DIV cycles.
- At the end of HIGH, if bit_cnt == FRAME_W-1, go to HOLD with sck=0.
- Otherwise bit_cnt increments and tx_sh shifts left, so mosi shows the next bit in the same cycle sck falls. Go to LOW.
- HOLD: ss=0, sck=0, mosi held, for CS_HOLD cycles.
- On exit from HOLD, in one cycle: ss=1, busy=0, done=1, rx_data=rx_sh, state IDLE.
- Frame length: busy stays high exactly CS_SETUP + 2*CLK_DIV*FRAME_W + CS_HOLD cycles. sck shows exactly FRAME_W rising edges per frame.
- Back-to-back frames: start is legal in the done cycle because busy=0. ss then stays high for exactly 1 cycle before the next SETUP.
- Divider counter width is clog2(CLK_DIV)+1. With CLK_DIV=1, sck toggles every clk cycle.
- done never asserts without a completed frame. rx_data holds its value between frames.

Test Plan:
1. Defaults, miso tied to mosi, start with tx_data=0xA5C3 -> 16 sck rises, mosi bit sequence 1010_0101_1100_0011, busy high 132 cycles, done 1 cycle, rx_data=0xA5C3, ss high after.
2. Slave model returns 0x1234 MSB-first, changing miso on sck fall; send 0xFFFF -> rx_data=0x1234, and the slave model captured 0xFFFF.
3. start pulsed again 10 cycles into a frame with tx_data=0x0001 -> ignored: only one frame, one done, captured mosi = first tx_data.
4. rst=1 at cycle 40 of a frame -> next edge ss=1, sck=0, busy=0, rx_data=0, no done. A subsequent start of 0x00FF completes normally.
5. start held high through done -> second frame starts. ss high exactly 1 cycle between frames, two done pulses 133 cycles apart.
6. CLK_DIV=1, FRAME_W=8, CS_SETUP=CS_HOLD=1, loopback 0x81 -> sck period 2 clk cycles, busy 18 cycles, rx_data=0x81.
